// File: rtl/reqack_arbiter_n2one_pkg.sv
// Shared constants and helpers for the N-to-1 req/ack arbiter.
package reqack_arbiter_n2one_pkg;

  localparam int SYNC_STAGES_DEF = 2;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int cyc_idx(
    input int base,
    input int off,
    input int n
  );
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/reqack_sync_bit.sv
// Reset-to-0 flop chain synchroniser for one asynchronous bit.
module reqack_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/reqack_arbiter_n2one.sv
// Round-robin N-to-1 arbiter for 4-phase req/ack channels.
// Define REQACK_ARB_SRC_ID_EN to add the cons_src source-id output.
module reqack_arbiter_n2one
  import reqack_arbiter_n2one_pkg::*;
#(
  parameter  int NCH         = 4,
  parameter  int DWIDTH      = 8,
  parameter  int SYNC_STAGES = SYNC_STAGES_DEF,
  localparam int SW          = clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        prod_req,
  output logic [NCH-1:0]        prod_ack,
  input  logic [NCH*DWIDTH-1:0] prod_dat,
  output logic                  cons_req,
  input  logic                  cons_ack,
`ifdef REQACK_ARB_SRC_ID_EN
  output logic [SW-1:0]         cons_src,
`endif
  output logic [DWIDTH-1:0]     cons_dat
);

  logic [NCH-1:0]    req_s;
  logic [NCH-1:0]    pend;
  logic [NCH-1:0]    req_i;
  logic [NCH-1:0]    req_d;
  logic [NCH-1:0]    cand;
  logic              ack_s;
  logic              ack_d;
  logic              busy;
  logic              gnt_vld;
  logic [SW-1:0]     gnt_idx;
  logic [SW-1:0]     last_grant;
  logic [DWIDTH-1:0] dat_a [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    reqack_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_req (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (prod_req[i]),
      .q     (req_s[i])
    );
    assign dat_a[i] = prod_dat[i*DWIDTH +: DWIDTH];
  end

  reqack_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cons_ack),
    .q     (ack_s)
  );

  // pend keeps a granted request alive until the consumer handshake ends
  assign req_i = req_s | pend;
  assign busy  = |pend;
  assign cand  = req_i & ~prod_ack & {NCH{~busy}};

  always_comb begin
    logic [SW-1:0] ci;
    ci      = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NCH; k++) begin
      ci = SW'(cyc_idx(int'(last_grant), k, NCH));
      if (!gnt_vld && cand[ci]) begin
        gnt_vld = 1'b1;
        gnt_idx = ci;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_ack   <= '0;
      cons_req   <= 1'b0;
      cons_dat   <= '0;
      pend       <= '0;
      req_d      <= '0;
      ack_d      <= 1'b0;
      last_grant <= SW'(NCH-1);
`ifdef REQACK_ARB_SRC_ID_EN
      cons_src   <= '0;
`endif
    end else begin
      req_d <= req_i;
      ack_d <= ack_s;
      if (cons_req && ack_s) cons_req <= 1'b0;
      if (ack_d && !ack_s)   pend     <= '0;
      for (int i = 0; i < NCH; i++)
        if (req_d[i] && !req_i[i]) prod_ack[i] <= 1'b0;
      if (gnt_vld) begin
        cons_req          <= 1'b1;
        cons_dat          <= dat_a[gnt_idx];
        prod_ack[gnt_idx] <= 1'b1;
        pend[gnt_idx]     <= 1'b1;
        last_grant        <= gnt_idx;
`ifdef REQACK_ARB_SRC_ID_EN
        cons_src          <= gnt_idx;
`endif
      end
    end
  end

endmodule
